morse_sequencer: RTL and testbench

MORSE_SEQUENCER -- requirements
Module: morse_sequencer

---
 rtl/morse_sequencer.sv | 156 +++++++++++++++
 tb/tb_morse_sequencer.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/morse_sequencer.sv
// Morse code character sequencer: turns one ASCII character into
// timed LED marks and gaps (dot = 1 unit, dash = 3, char gap = 3, word gap = 7).
module morse_sequencer #(
  parameter int unsigned UNIT_CYCLES = 4800000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_valid,
  input  logic [7:0] i_char,
  output logic       o_ready,
  output logic       o_led_n,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(7 * UNIT_CYCLES + 1);
  localparam logic [CW-1:0] T1 = CW'(UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T3 = CW'(3 * UNIT_CYCLES - 1);
  localparam logic [CW-1:0] T7 = CW'(7 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, MARK, GAP, CGAP, WGAP
  } state_t;

  state_t      state, state_n;
  logic [7:0]  char_q;
  logic [4:0]  pat;
  logic [2:0]  len;
  logic [2:0]  idx;
  logic [CW-1:0] cnt, cnt_n;

  logic [7:0]  up;
  logic        ok;
  logic        is_sp;
  logic [2:0]  d_len;
  logic [4:0]  d_raw;
  logic [4:0]  d_pat;
  logic [4:0]  pat_sh;
  logic        nxt_bit;
  logic        cnt_zero;

  // Table holds {length, symbols right-aligned}; d_pat left-aligns them
  always_comb begin
    up = char_q;
    if (char_q >= "a" && char_q <= "z")
      up = char_q - 8'd32;
    ok = 1'b1;
    {d_len, d_raw} = 8'd0;
    case (up)
      "A": {d_len, d_raw} = {3'd2, 5'b00001};
      "B": {d_len, d_raw} = {3'd4, 5'b01000};
      "C": {d_len, d_raw} = {3'd4, 5'b01010};
      "D": {d_len, d_raw} = {3'd3, 5'b00100};
      "E": {d_len, d_raw} = {3'd1, 5'b00000};
      "F": {d_len, d_raw} = {3'd4, 5'b00010};
      "G": {d_len, d_raw} = {3'd3, 5'b00110};
      "H": {d_len, d_raw} = {3'd4, 5'b00000};
      "I": {d_len, d_raw} = {3'd2, 5'b00000};
      "J": {d_len, d_raw} = {3'd4, 5'b00111};
      "K": {d_len, d_raw} = {3'd3, 5'b00101};
      "L": {d_len, d_raw} = {3'd4, 5'b00100};
      "M": {d_len, d_raw} = {3'd2, 5'b00011};
      "N": {d_len, d_raw} = {3'd2, 5'b00010};
      "O": {d_len, d_raw} = {3'd3, 5'b00111};
      "P": {d_len, d_raw} = {3'd4, 5'b00110};
      "Q": {d_len, d_raw} = {3'd4, 5'b01101};
      "R": {d_len, d_raw} = {3'd3, 5'b00010};
      "S": {d_len, d_raw} = {3'd3, 5'b00000};
      "T": {d_len, d_raw} = {3'd1, 5'b00001};
      "U": {d_len, d_raw} = {3'd3, 5'b00001};
      "V": {d_len, d_raw} = {3'd4, 5'b00001};
      "W": {d_len, d_raw} = {3'd3, 5'b00011};
      "X": {d_len, d_raw} = {3'd4, 5'b01001};
      "Y": {d_len, d_raw} = {3'd4, 5'b01011};
      "Z": {d_len, d_raw} = {3'd4, 5'b01100};
      "0": {d_len, d_raw} = {3'd5, 5'b11111};
      "1": {d_len, d_raw} = {3'd5, 5'b01111};
      "2": {d_len, d_raw} = {3'd5, 5'b00111};
      "3": {d_len, d_raw} = {3'd5, 5'b00011};
      "4": {d_len, d_raw} = {3'd5, 5'b00001};
      "5": {d_len, d_raw} = {3'd5, 5'b00000};
      "6": {d_len, d_raw} = {3'd5, 5'b10000};
      "7": {d_len, d_raw} = {3'd5, 5'b11000};
      "8": {d_len, d_raw} = {3'd5, 5'b11100};
      "9": {d_len, d_raw} = {3'd5, 5'b11110};
      default: ok = 1'b0;
    endcase
    d_pat = d_raw << (3'd5 - d_len);
    is_sp = (char_q == 8'h20);
  end

  assign cnt_zero = (cnt == '0);
  assign pat_sh   = pat << (idx + 3'd1);
  assign nxt_bit  = (state == LOAD) ? d_pat[4] : pat_sh[4];

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (i_valid) state_n = LOAD;
      LOAD: begin
        if (ok)         state_n = MARK;
        else if (is_sp) state_n = WGAP;
        else            state_n = IDLE;
      end
      MARK: if (cnt_zero)
        state_n = (3'(idx + 3'd1) < len) ? GAP : CGAP;
      GAP:  if (cnt_zero) state_n = MARK;
      CGAP: if (cnt_zero) state_n = IDLE;
      WGAP: if (cnt_zero) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Reload on every state entry so the counter never wraps
  always_comb begin
    cnt_n = cnt_zero ? '0 : cnt - 1'b1;
    if (state_n != state) begin
      unique case (state_n)
        MARK:    cnt_n = nxt_bit ? T3 : T1;
        GAP:     cnt_n = T1;
        CGAP:    cnt_n = T3;
        WGAP:    cnt_n = T7;
        default: cnt_n = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pat     <= '0;
      len     <= '0;
      idx     <= '0;
      char_q  <= '0;
      o_led_n <= 1'b1;
      o_ready <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      o_led_n <= (state_n != MARK);
      o_ready <= (state_n == IDLE);
      o_busy  <= (state_n != IDLE);
      if (o_ready && i_valid)
        char_q <= i_char;
      if (state == LOAD) begin
        pat <= d_pat;
        len <= d_len;
        idx <= '0;
      end else if (state == GAP && cnt_zero) begin
        idx <= idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_morse_sequencer.sv
// Bench for morse_sequencer: per-cycle expected {led_n,ready,busy}
// traces are queued when a character is sent and popped every cycle.
module tb_morse_sequencer;

  localparam int U = 4;

  logic       i_clk = 0;
  logic       i_rst = 1;
  logic       i_valid = 0;
  logic [7:0] i_char = 0;
  logic       o_ready;
  logic       o_led_n;
  logic       o_busy;

  int total = 0;
  int bad = 0;
  logic [2:0] q[$];

  morse_sequencer #(.UNIT_CYCLES(U)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_valid(i_valid),
    .i_char(i_char),
    .o_ready(o_ready),
    .o_led_n(o_led_n),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  function automatic string morse(input logic [7:0] c);
    logic [7:0] u;
    u = c;
    if (u >= "a" && u <= "z") u = u - 8'd32;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";
      "D": return "-..";   "E": return ".";     "F": return "..-.";
      "G": return "--.";   "H": return "....";  "I": return "..";
      "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";
      "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
      "S": return "...";   "T": return "-";     "U": return "..-";
      "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---";
      "3": return "...--"; "4": return "....-"; "5": return ".....";
      "6": return "-...."; "7": return "--..."; "8": return "---..";
      "9": return "----.";
      default: return "";
    endcase
  endfunction

  // Trace entries are {led_n, ready, busy}, one per cycle after accept
  task automatic push_char(input logic [7:0] c);
    string p;
    p = morse(c);
    q.push_back(3'b101);
    if (c == 8'h20) begin
      repeat (7 * U) q.push_back(3'b101);
    end else if (p.len() > 0) begin
      for (int i = 0; i < p.len(); i++) begin
        repeat ((p[i] == "-") ? 3 * U : U) q.push_back(3'b001);
        if (i < p.len() - 1)
          repeat (U) q.push_back(3'b101);
      end
      repeat (3 * U) q.push_back(3'b101);
    end
    q.push_back(3'b110);
  endtask

  task automatic start(input logic [7:0] c, input bit hold);
    int w;
    w = 0;
    @(negedge i_clk);
    while (o_ready !== 1'b1 && w < 200) begin
      @(negedge i_clk);
      w++;
    end
    total++;
    if (o_ready !== 1'b1) begin
      bad++;
      $display("FAIL start_ready got %b want 1", o_ready);
    end
    i_char = c;
    i_valid = 1;
    push_char(c);
    @(posedge i_clk);
    #1;
    if (!hold) i_valid = 0;
  endtask

  task automatic run_q(input string nm, input int drop_at, input int stop_at);
    int n;
    logic [2:0] exp_v;
    logic [2:0] act_v;
    n = 0;
    while (q.size() > 0 && (stop_at < 0 || n < stop_at)) begin
      @(negedge i_clk);
      exp_v = q.pop_front();
      act_v = {o_led_n, o_ready, o_busy};
      total++;
      if (act_v !== exp_v) begin
        bad++;
        $display("FAIL %s cyc%0d led/rdy/busy got %b want %b",
                 nm, n + 1, act_v, exp_v);
      end
      n++;
      if (n == drop_at || q.size() == 0) i_valid = 0;
    end
  endtask

  task automatic expect_idle(input string nm);
    total++;
    if ({o_led_n, o_ready, o_busy} !== 3'b110) begin
      bad++;
      $display("FAIL %s got %b want 110", nm, {o_led_n, o_ready, o_busy});
    end
  endtask

  task automatic test_reset;
    i_rst = 1;
    i_valid = 1;
    i_char = "E";
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    expect_idle("reset");
    i_rst = 0;
    i_valid = 0;
    @(negedge i_clk);
    expect_idle("reset_discard");
  endtask

  task automatic test_single;
    start("E", 0);
    run_q("E", -1, -1);
    start("S", 0);
    run_q("S", -1, -1);
    start("o", 0);
    run_q("o", -1, -1);
    start("k", 0);
    run_q("k", -1, -1);
    start("7", 0);
    run_q("7", -1, -1);
  endtask

  task automatic test_space_invalid;
    start(" ", 0);
    run_q("space", -1, -1);
    start("#", 0);
    run_q("hash", -1, -1);
  endtask

  task automatic test_hold;
    start("T", 1);
    run_q("hold_T", 4, -1);
    repeat (3) q.push_back(3'b110);
    run_q("hold_idle", -1, -1);
  endtask

  task automatic test_back_to_back;
    start("0", 1);
    push_char("0");
    push_char("0");
    run_q("b2b", -1, -1);
  endtask

  task automatic test_reset_mid;
    start("H", 0);
    run_q("H_pre", -1, 11);
    i_rst = 1;
    @(negedge i_clk);
    expect_idle("H_rst");
    i_rst = 0;
    q.delete();
    @(negedge i_clk);
    expect_idle("H_after");
    start("E", 0);
    run_q("E_after_rst", -1, -1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_space_invalid();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
